// File: rtl/uart_word_serializer.sv
// Word-to-byte serializer: buffers whole words in a small FIFO and emits them
// one byte per valid/ready transfer, MSB-first or LSB-first.
module uart_word_serializer #(
  parameter int WORD_BYTES = 2,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [8*WORD_BYTES-1:0]       word_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  output logic [7:0]                    tx_byte_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o,
  output logic [15:0]                   words_sent_o
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mem_q [FIFO_DEPTH];
  logic [W-1:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     sent_q, sent_d;

  logic fifo_empty, xfer, last_byte, push, pop;

  always_comb begin
    fifo_empty = (count_q == '0);
    xfer       = (state_q == SEND) && tx_ready_i;
    last_byte  = (idx_q == LAST_IDX);
    // A full FIFO refuses the push even when a pop happens on the same edge.
    push       = word_valid_i && (count_q != FULL_CNT);
    pop        = !fifo_empty && ((state_q == IDLE) || (xfer && last_byte));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shreg_q  <= '0;
      idx_q    <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      sent_q   <= sent_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SEND;
      SEND:    if (xfer && last_byte && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = word_i;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (pop) begin
      shreg_d = mem_q[rd_ptr_q];
      idx_d   = '0;
    end else if (xfer && !last_byte) begin
      shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
      idx_d   = idx_q + 1'b1;
    end

    sent_d = sent_q;
    if (xfer && last_byte) sent_d = sent_q + 16'd1;
  end

  always_comb begin
    tx_valid_o   = (state_q == SEND);
    tx_byte_o    = MSB_FIRST ? shreg_q[W-1 -: 8] : shreg_q[7:0];
    word_ready_o = (count_q != FULL_CNT);
    fifo_count_o = count_q;
    busy_o       = (state_q == SEND) || !fifo_empty;
    words_sent_o = sent_q;
  end

endmodule

// File: tb/tb_uart_word_serializer.sv
// Bench for uart_word_serializer: three configurations checked every cycle
// against a byte-queue model, plus directed literal expectations.
module tb_uart_word_serializer;

  localparam int WBS [3] = '{2, 4, 1};
  localparam bit MSB [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wv   [3];
  logic        trdy [3];
  logic [15:0] wd0;
  logic [31:0] wd1;
  logic [7:0]  wd2;
  logic        wr   [3];
  logic [7:0]  txb  [3];
  logic        txv  [3];
  logic [2:0]  fc   [3];
  logic        bsy  [3];
  logic [15:0] ws   [3];

  uart_word_serializer #(.WORD_BYTES(2), .MSB_FIRST(1'b1), .FIFO_DEPTH(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .word_i(wd0), .word_valid_i(wv[0]), .word_ready_o(wr[0]),
    .tx_byte_o(txb[0]), .tx_valid_o(txv[0]), .tx_ready_i(trdy[0]), .fifo_count_o(fc[0]),
    .busy_o(bsy[0]), .words_sent_o(ws[0]));
  uart_word_serializer #(.WORD_BYTES(4), .MSB_FIRST(1'b0), .FIFO_DEPTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .word_i(wd1), .word_valid_i(wv[1]), .word_ready_o(wr[1]),
    .tx_byte_o(txb[1]), .tx_valid_o(txv[1]), .tx_ready_i(trdy[1]), .fifo_count_o(fc[1]),
    .busy_o(bsy[1]), .words_sent_o(ws[1]));
  uart_word_serializer #(.WORD_BYTES(1), .MSB_FIRST(1'b1), .FIFO_DEPTH(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .word_i(wd2), .word_valid_i(wv[2]), .word_ready_o(wr[2]),
    .tx_byte_o(txb[2]), .tx_valid_o(txv[2]), .tx_ready_i(trdy[2]), .fifo_count_o(fc[2]),
    .busy_o(bsy[2]), .words_sent_o(ws[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted word becomes a queue of bytes in transmit order.
  logic [7:0] expb [3][256];
  int         hd [3], tl [3], acc [3], done [3], nb [3];
  logic       etxv [3], stl [3];
  logic [7:0] stb [3];
  logic [7:0] lg [3][64];
  int         lgn [3];

  function automatic logic [31:0] wget(input int i);
    case (i)
      0:       return {16'h0, wd0};
      1:       return wd1;
      default: return {24'h0, wd2};
    endcase
  endfunction

  initial begin
    int pend, comp, sh;
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0; tl[i] = 0; acc[i] = 0; done[i] = 0; nb[i] = 0;
      etxv[i] = 1'b0; stl[i] = 1'b0; stb[i] = 8'h0; lgn[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          chk("rst_tx_valid", 32'(txv[i]), 0);
          chk("rst_tx_byte", 32'(txb[i]), 0);
          chk("rst_word_ready", 32'(wr[i]), 1);
          chk("rst_fifo_count", 32'(fc[i]), 0);
          chk("rst_busy", 32'(bsy[i]), 0);
          chk("rst_words_sent", 32'(ws[i]), 0);
          hd[i] = 0; tl[i] = 0; acc[i] = 0; done[i] = 0; nb[i] = 0;
          etxv[i] = 1'b0; stl[i] = 1'b0;
        end else begin
          pend = acc[i] - done[i];
          chk("tx_valid", 32'(txv[i]), 32'(etxv[i]));
          chk("fifo_count", 32'(fc[i]), 32'(pend - int'(etxv[i])));
          chk("busy", 32'(bsy[i]), 32'(pend != 0));
          chk("word_ready", 32'(wr[i]), 32'((pend - int'(etxv[i])) != 4));
          chk("words_sent", 32'(ws[i]), 32'(done[i] & 16'hFFFF));
          if (stl[i]) begin
            chk("stall_valid_hold", 32'(txv[i]), 1);
            chk("stall_byte_hold", 32'(txb[i]), 32'(stb[i]));
          end
          comp = 0;
          if (txv[i] && trdy[i]) begin
            chk("tx_byte", 32'(txb[i]), (hd[i] < tl[i]) ? 32'(expb[i][hd[i] % 256]) : 32'h100);
            lg[i][lgn[i] % 64] = txb[i];
            lgn[i]++;
            hd[i]++;
            nb[i]++;
            if (nb[i] == WBS[i]) begin
              nb[i] = 0;
              done[i]++;
              comp = 1;
            end
          end
          stl[i] = txv[i] && !trdy[i];
          stb[i] = txb[i];
          if (wv[i] && wr[i]) begin
            w = wget(i);
            for (int b = 0; b < WBS[i]; b++) begin
              sh = MSB[i] ? (WBS[i] - 1 - b) : b;
              expb[i][tl[i] % 256] = 8'(w >> (8 * sh));
              tl[i]++;
            end
            acc[i]++;
          end
          // Outstanding words older than this edge keep the transmitter busy.
          etxv[i] = (pend - comp) > 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [15:0] w);
    wd0 = w;
    wv[0] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (wr[0]) begin
        tick();
        wv[0] = 1'b0;
        return;
      end
      tick();
    end
    chk("push0_accept", 32'(wr[0]), 1);
    wv[0] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int n = 0; n < 40 && bsy[i]; n++) tick();
    chk("drain_idle", 32'(bsy[i]), 0);
  endtask

  initial begin
    int base, got;
    logic a;
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1'b0;
      trdy[i] = 1'b0;
    end
    wd0 = '0; wd1 = '0; wd2 = '0;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic a;
    #1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // MSB-first 16-bit word
    trdy[0] = 1'b1;
    base = lgn[0];
    wd0 = 16'hA55A; wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    chk("a_valid_k", 32'(txv[0]), 0);
    chk("a_count_k", 32'(fc[0]), 1);
    tick();
    chk("a_valid_k1", 32'(txv[0]), 1);
    chk("a_byte0", 32'(txb[0]), 32'hA5);
    tick();
    chk("a_byte1", 32'(txb[0]), 32'h5A);
    tick();
    chk("a_idle", 32'(txv[0]), 0);
    chk("a_sent", 32'(ws[0]), 1);
    chk("a_busy", 32'(bsy[0]), 0);
    chk("a_log0", 32'(lg[0][base % 64]), 32'hA5);
    chk("a_log1", 32'(lg[0][(base + 1) % 64]), 32'h5A);

    // LSB-first 32-bit word with a mid-word stall
    trdy[1] = 1'b1;
    wd1 = 32'h11223344; wv[1] = 1'b1;
    tick();
    wv[1] = 1'b0;
    chk("b_count", 32'(fc[1]), 1);
    tick();
    chk("b_byte0", 32'(txb[1]), 32'h44);
    tick();
    chk("b_byte1", 32'(txb[1]), 32'h33);
    trdy[1] = 1'b0;
    tick();
    chk("b_stall_byte", 32'(txb[1]), 32'h33);
    chk("b_stall_valid", 32'(txv[1]), 1);
    tick();
    chk("b_stall_byte2", 32'(txb[1]), 32'h33);
    trdy[1] = 1'b1;
    tick();
    chk("b_byte2", 32'(txb[1]), 32'h22);
    tick();
    chk("b_byte3", 32'(txb[1]), 32'h11);
    tick();
    chk("b_idle", 32'(txv[1]), 0);
    chk("b_sent", 32'(ws[1]), 1);

    // Back-pressure: fill to full, then push against full while popping
    trdy[0] = 1'b0;
    base = lgn[0];
    for (int k = 0; k < 5; k++) push0(16'((2 * k + 1) << 8 | (2 * k + 2)));
    chk("bp_count_full", 32'(fc[0]), 4);
    chk("bp_ready_low", 32'(wr[0]), 0);
    chk("bp_head_byte", 32'(txb[0]), 32'h01);
    wd0 = 16'h0B0C; wv[0] = 1'b1;
    tick();
    chk("bp_still_full", 32'(fc[0]), 4);
    trdy[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("bp_gapfree", 32'(txv[0]), 1);
      if (k == 2) chk("bp_full_pop_count", 32'(fc[0]), 3);
      a = wv[0] && wr[0];
      tick();
      if (a) wv[0] = 1'b0;
    end
    chk("bp_done_idle", 32'(txv[0]), 0);
    chk("bp_sent", 32'(ws[0]), 7);
    for (int k = 0; k < 12; k++) chk("bp_order", 32'(lg[0][(base + k) % 64]), 32'(k + 1));

    // Simultaneous push and pop at count 2
    trdy[0] = 1'b0;
    push0(16'h2122); push0(16'h2324); push0(16'h2526);
    chk("sp_count_pre", 32'(fc[0]), 2);
    trdy[0] = 1'b1;
    tick();
    wd0 = 16'h2728; wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    chk("sp_count_same", 32'(fc[0]), 2);
    drain(0);
    chk("sp_sent", 32'(ws[0]), 11);

    // Asynchronous reset in the middle of a word
    push0(16'hBEEF);
    tick();
    chk("r_byte0", 32'(txb[0]), 32'hBE);
    tick();
    chk("r_byte1", 32'(txb[0]), 32'hEF);
    rst = 1'b1;
    #1;
    chk("r_async_valid", 32'(txv[0]), 0);
    chk("r_async_byte", 32'(txb[0]), 0);
    chk("r_async_sent", 32'(ws[0]), 0);
    chk("r_async_ready", 32'(wr[0]), 1);
    tick(); tick();
    rst = 1'b0;
    tick();
    base = lgn[0];
    push0(16'h1234);
    drain(0);
    chk("r_new0", 32'(lg[0][base % 64]), 32'h12);
    chk("r_new1", 32'(lg[0][(base + 1) % 64]), 32'h34);
    chk("r_sent", 32'(ws[0]), 1);

    // words_sent wrap with single-byte words streamed back-to-back
    trdy[2] = 1'b1;
    wv[2] = 1'b1;
    n = 0;
    for (int c = 0; c < 70000 && n < 65536; c++) begin
      wd2 = 8'(n) ^ 8'h5A;
      a = wr[2];
      tick();
      if (a) n++;
    end
    wv[2] = 1'b0;
    chk("w_pushed", 32'(n), 65536);
    drain(2);
    chk("w_wrapped", 32'(ws[2]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
